// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM state type and default widths for mem_port_arbiter.
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, RESP} arb_state_t;
    localparam int AW_DEF = 8;
    localparam int DW_DEF = 16;
endpackage

// File: rtl/mem_port_arbiter_pick.sv
// arb_pick: combinational winner select; round-robin after `last` with MEM_ARB_RR_EN, else lowest index wins.
module arb_pick #(
    parameter int NREQ = 2,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [IW-1:0]   win_idx,
    output logic            any
);
`ifdef MEM_ARB_RR_EN
    logic [IW-1:0] idx;
    // Scan from farthest to nearest so the first requester after `last` is assigned last and wins.
    always_comb begin
        win_idx = '0;
        idx = '0;
        any = |req;
        for (int k = NREQ; k >= 1; k--) begin
            idx = IW'((int'(last) + k) % NREQ);
            if (req[idx]) win_idx = idx;
        end
    end
`else
    logic unused_last;
    assign unused_last = ^last;
    always_comb begin
        win_idx = '0;
        any = |req;
        for (int i = NREQ - 1; i >= 0; i--)
            if (req[IW'(i)]) win_idx = IW'(i);
    end
`endif
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: one-transaction-at-a-time sharing of a single-port sync-read RAM among NREQ requesters.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int AW   = AW_DEF,
    parameter int DW   = DW_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    we,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ*DW-1:0] wdata,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    rvalid,
    output logic [DW-1:0]      rdata,
    output logic [AW-1:0]      mem_addr,
    output logic               mem_write,
    output logic [DW-1:0]      mem_din,
    input  logic [DW-1:0]      mem_dout
);
    localparam int IW = $clog2(NREQ);
    arb_state_t state, state_n;
    logic [IW-1:0] owner, last, win_idx;
    logic any, we_r;
    logic [AW-1:0] addr_r;
    logic [DW-1:0] wdata_r, rdata_r;
    logic [NREQ-1:0] owner_oh;

    arb_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req(req),
        .last(last),
        .win_idx(win_idx),
        .any(any)
    );

    assign owner_oh = NREQ'(1) << owner;
    assign mem_addr = addr_r;
    assign mem_din = wdata_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            owner <= '0;
            last <= IW'(NREQ - 1);
            we_r <= 1'b0;
            addr_r <= '0;
            wdata_r <= '0;
            rdata_r <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && any) begin
                owner <= win_idx;
                last <= win_idx;
                we_r <= we[win_idx];
                addr_r <= addr[win_idx*AW +: AW];
                wdata_r <= wdata[win_idx*DW +: DW];
            end
            if (state == RESP) rdata_r <= mem_dout;
        end
    end

    // Outputs are masked while reset is high so an in-flight transaction neither writes nor responds.
    always_comb begin
        state_n = state;
        gnt = '0;
        rvalid = '0;
        mem_write = 1'b0;
        rdata = rdata_r;
        case (state)
            IDLE: state_n = any ? BUSY : IDLE;
            BUSY: begin
                state_n = we_r ? IDLE : RESP;
                gnt = reset ? '0 : owner_oh;
                mem_write = we_r & ~reset;
            end
            RESP: begin
                state_n = IDLE;
                rvalid = reset ? '0 : owner_oh;
                rdata = reset ? rdata_r : mem_dout;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule
